// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock, start/done handshake.
// Optional build macro BCD_SAT_EN: clamp every tetrad to 9 when the result overflows D digits.
module bin2bcd_seq #(
  parameter int BW = 8,
  parameter int D  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BW-1:0]   bin,
  output logic            busy,
  output logic            done,
  output logic [4*D-1:0]  bcd,
  output logic            ovf
);

  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [BW-1:0]   shift_reg;
  logic [4*D-1:0]  digits_reg;
  logic            ovf_work_reg;
  logic [CW-1:0]   count_reg;

  logic [4*D-1:0]  adjusted;
  logic [4*D-1:0]  digits_next;
  logic [BW-1:0]   shift_next;
  logic            ovf_next;
  logic [4*D-1:0]  result_next;

  // Per-tetrad +3 correction; no carry crosses into the neighbouring tetrad.
  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_adj
      assign adjusted[4*gi +: 4] = (digits_reg[4*gi +: 4] >= 4'd5)
                                   ? digits_reg[4*gi +: 4] + 4'd3
                                   : digits_reg[4*gi +: 4];
    end
  endgenerate

  assign digits_next = {adjusted[4*D-2:0], shift_reg[BW-1]};
  assign shift_next  = shift_reg << 1;
  // Any bit pushed out of the top tetrad means the value needs more than D digits.
  assign ovf_next    = ovf_work_reg | adjusted[4*D-1];

`ifdef BCD_SAT_EN
  assign result_next = ovf_next ? {D{4'h9}} : digits_next;
`else
  assign result_next = digits_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      digits_reg   <= '0;
      ovf_work_reg <= 1'b0;
      count_reg    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bcd          <= '0;
      ovf          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            shift_reg    <= bin;
            digits_reg   <= '0;
            ovf_work_reg <= 1'b0;
            count_reg    <= CW'(BW - 1);
            busy         <= 1'b1;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_reg    <= shift_next;
          digits_reg   <= digits_next;
          ovf_work_reg <= ovf_next;
          if (count_reg == '0) begin
            // Final shift: publish the result so it is valid alongside done.
            bcd       <= result_next;
            ovf       <= ovf_next;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
